window_3x3_stream_ctrl: RTL and testbench
=========================================

// Module: window_3x3_stream_ctrl
// PURPOSE
//   Sequencing controller for the 3x3 window-buffer datapath. Accepts one column
//   (three vertically adjacent pixels from the line buffers) per cycle.
//   Drives the datapath shift/count enable and tags each valid 3x3 window with its
//   (row, col) position. Signals row ends and frame completion.
//   Sits between the line-buffer stage and the window consumer (median/conv filter).
// PARAMETERS
//   COLS  5  image width in pixels; 3 <= COLS <= 1023
//   ROWS  5  image height in pixels; 3 <= ROWS <= 1023
//            The frame carries ROWS-2 column-triple rows of COLS columns each.
//            The frame produces (ROWS-2)*(COLS-2) windows.
// PORTS
//   clk           in   1   clock, all logic on rising edge
//   rst           in   1   synchronous, active-high reset
//   start_i       in   1   begin frame; sampled only in IDLE
//   valid_i       in   1   column triple present on datapath S1_i..S3_i this cycle
//   ready_o       out  1   controller accepts columns (high only in RUN)
//   count_en_o    out  1   valid_i & ready_o; column accepted; drives datapath counters
//   win_valid_o   out  1   datapath S1_o..S9_o hold a complete window this cycle
//   win_col_o     out  10  column index of window centre minus 1 (0..COLS-3)
//   win_row_o     out  10  row index of window centre minus 1 (0..ROWS-3)
//   row_end_o     out  1   with win_valid_o: last window of a row
//   frame_done_o  out  1   one-cycle pulse after the last window of the frame
//   busy_o        out  1   state != IDLE
//   err_o         out  1   sticky: valid_i low mid-row (gap); cleared on accepted start_i
// BEHAVIOUR
//   Reset: state IDLE; all counters, pipeline tags and outputs are 0.
//     Reset mid-frame aborts the frame immediately, with no frame_done_o.
//   FSM:
//     IDLE  --start_i-->                          RUN
//     RUN   --last col of last row accepted-->    FLUSH
//     FLUSH --2 cycles-->                         DONE
//     DONE  --1 cycle-->                          IDLE
//     start_i outside IDLE is ignored.
//   Counters (10-bit) and contiguity counter:
//     col_cnt: 0..COLS-1. +1 per accepted column; wraps to 0 after COLS-1, and row_cnt +1 on wrap.
//     row_cnt: 0..ROWS-3. Both clear on accepted start_i.
//     run: consecutive accepted columns in the current row, saturating at 3.
//       Clears at row start and on any gap.
//   Gap: in RUN with valid_i=0 and col_cnt!=0:
//     - err_o is set; counters hold.
//     - run clears, so windows straddling the gap are never tagged valid.
//     - the datapath still shifts, so a bubble column enters the window.
//     valid_i=0 with col_cnt==0 (between rows) is legal; err_o is not set.
//   Window tag at acceptance cycle t:
//     tag = accepted & (col_cnt>=2) & (run>=2), where run is the value before the increment.
//     Position: col = col_cnt-2, row = row_cnt; last = tag & col_cnt==COLS-1.
//   Latency: a 2-stage tag pipeline matches the datapath.
//     win_valid_o / win_col_o / win_row_o / row_end_o appear at cycle t+2.
//     win_col_o and win_row_o are 0 when win_valid_o=0.
//   Completion: the FLUSH cycles drain the tag pipeline (ready_o=0).
//     frame_done_o pulses in DONE, i.e. exactly 1 cycle after the final win_valid_o.
//   Arithmetic: unsigned 10-bit throughout; no overflow within parameter limits.
// TESTING
//   1 Reset: rst=1 for 2 cycles with valid_i=1
//       -> all outputs 0, busy_o=0, ready_o=0.
//   2 Nominal 5x5: start_i then 15 contiguous valid_i cycles
//       -> 9 windows with (row,col) = (0,0)..(2,2) in raster order.
//       -> first win_valid_o 4 cycles after the first accept (accept+2 for col 2).
//       -> row_end_o on col 2 of each row; frame_done_o 1 cycle after the 9th window.
//   3 Row gaps: 1-cycle valid_i=0 between every row of a 5x5 frame
//       -> same 9 windows; err_o stays 0.
//   4 Mid-row gap: row 0, valid_i=0 after col 2
//       -> err_o=1 (sticky).
//       -> row 0 windows at col 0 only; cols 1 and 2 of row 0 are suppressed.
//       -> rows 1-2 are normal.
//   5 Reset mid-frame: rst after 7 accepts, then a new start_i and a clean frame
//       -> no frame_done_o for the aborted frame; the new frame yields 9 correct windows.
//   6 start_i during RUN and FLUSH
//       -> ignored; counters are unaffected; COLS=8, ROWS=4 run yields 12 windows.

Source files
------------

// File: rtl/window_3x3_stream_ctrl.sv
// Sequencing controller for the 3x3 window datapath: accepts one column triple per
// cycle, tags complete windows with their (row, col) position and flags frame completion.
//
// state  | meaning
// IDLE   | waiting for start_i
// RUN    | accepting columns, tagging windows
// FLUSH  | two cycles draining the tag pipeline
// DONE   | one-cycle frame_done_o pulse
module window_3x3_stream_ctrl #(
  parameter int COLS = 5,
  parameter int ROWS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       count_en_o,
  output logic       win_valid_o,
  output logic [9:0] win_col_o,
  output logic [9:0] win_row_o,
  output logic       row_end_o,
  output logic       frame_done_o,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam logic [9:0] COL_LAST = 10'(COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(ROWS - 3);

  state_t     state_q, state_d;
  logic [9:0] col_cnt_q, col_cnt_d;
  logic [9:0] row_cnt_q, row_cnt_d;
  logic [1:0] run_q, run_d;
  logic       flush_cnt_q, flush_cnt_d;
  logic       err_q, err_d;

  logic       accept;
  logic       tag;
  logic       tag_last;
  logic [9:0] tag_col;
  logic [9:0] tag_row;

  logic       s1_valid_q, s1_last_q, s2_valid_q, s2_last_q;
  logic [9:0] s1_col_q, s1_row_q, s2_col_q, s2_row_q;

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    run_d       = run_q;
    flush_cnt_d = flush_cnt_q;
    err_d       = err_q;

    accept   = (state_q == S_RUN) && valid_i;
    // run is checked before its increment so a window needs three contiguous columns
    tag      = accept && (col_cnt_q >= 10'd2) && (run_q >= 2'd2);
    tag_col  = tag ? (col_cnt_q - 10'd2) : '0;
    tag_row  = tag ? row_cnt_q : '0;
    tag_last = tag && (col_cnt_q == COL_LAST);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_RUN;
          col_cnt_d = '0;
          row_cnt_d = '0;
          run_d     = '0;
          err_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (valid_i) begin
          if (col_cnt_q == COL_LAST) begin
            col_cnt_d = '0;
            run_d     = '0;
            if (row_cnt_q == ROW_LAST) begin
              state_d     = S_FLUSH;
              flush_cnt_d = 1'b1;
            end else begin
              row_cnt_d = row_cnt_q + 10'd1;
            end
          end else begin
            col_cnt_d = col_cnt_q + 10'd1;
            run_d     = (run_q == 2'd3) ? 2'd3 : run_q + 2'd1;
          end
        end else if (col_cnt_q != '0) begin
          err_d = 1'b1;
          run_d = '0;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == 1'b0) state_d = S_DONE;
        else flush_cnt_d = flush_cnt_q - 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      run_q       <= '0;
      flush_cnt_q <= 1'b0;
      err_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_col_q    <= '0;
      s2_row_q    <= '0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      run_q       <= run_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
      s1_valid_q  <= tag;
      s1_last_q   <= tag_last;
      s1_col_q    <= tag_col;
      s1_row_q    <= tag_row;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      s2_col_q    <= s1_col_q;
      s2_row_q    <= s1_row_q;
    end
  end

  assign ready_o      = (state_q == S_RUN);
  assign count_en_o   = accept;
  assign win_valid_o  = s2_valid_q;
  assign win_col_o    = s2_col_q;
  assign win_row_o    = s2_row_q;
  assign row_end_o    = s2_last_q;
  assign frame_done_o = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_window_3x3_stream_ctrl.sv
// Directed bench for window_3x3_stream_ctrl: a 5x5 instance and an 8x4 instance share
// the stimulus; a negedge monitor collects windows/pulses from the selected instance.
module tb_window_3x3_stream_ctrl;

  logic clk = 1'b0;
  logic rst, start_i, valid_i;

  logic       ready5, cen5, wv5, rend5, done5, busy5, err5;
  logic [9:0] col5, row5;
  logic       ready84, cen84, wv84, rend84, done84, busy84, err84;
  logic [9:0] col84, row84;

  window_3x3_stream_ctrl #(.COLS(5), .ROWS(5)) dut5 (
    .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i),
    .ready_o(ready5), .count_en_o(cen5), .win_valid_o(wv5),
    .win_col_o(col5), .win_row_o(row5), .row_end_o(rend5),
    .frame_done_o(done5), .busy_o(busy5), .err_o(err5));

  window_3x3_stream_ctrl #(.COLS(8), .ROWS(4)) dut84 (
    .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i),
    .ready_o(ready84), .count_en_o(cen84), .win_valid_o(wv84),
    .win_col_o(col84), .win_row_o(row84), .row_end_o(rend84),
    .frame_done_o(done84), .busy_o(busy84), .err_o(err84));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  logic sel84 = 1'b0;
  logic mon_en = 1'b0;

  int          acc_q[$];
  int          wcyc_q[$];
  int          done_q[$];
  logic [20:0] win_q[$];

  wire       m_cen  = sel84 ? cen84  : cen5;
  wire       m_wv   = sel84 ? wv84   : wv5;
  wire       m_end  = sel84 ? rend84 : rend5;
  wire       m_done = sel84 ? done84 : done5;
  wire       m_busy = sel84 ? busy84 : busy5;
  wire       m_err  = sel84 ? err84  : err5;
  wire [9:0] m_col  = sel84 ? col84  : col5;
  wire [9:0] m_row  = sel84 ? row84  : row5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_cen) acc_q.push_back(cyc);
      if (m_wv) begin
        win_q.push_back({m_row, m_col, m_end});
        wcyc_q.push_back(cyc);
      end else begin
        chk("idle_pos", {12'd0, m_row, m_col}, 32'd0);
      end
      if (m_done) done_q.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    acc_q.delete();
    wcyc_q.delete();
    done_q.delete();
    win_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_i = 1'b0;
    valid_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    clear_q();
  endtask

  // mode: 0 plain, 1 gap between rows, 2 gap after row0 col2, 3 start_i noise in RUN/FLUSH
  task automatic run_frame(input int cols, input int rows, input int mode);
    start_i = 1'b1;
    valid_i = 1'b0;
    step();
    start_i = 1'b0;
    for (int r = 0; r < rows - 2; r++) begin
      for (int c = 0; c < cols; c++) begin
        valid_i = 1'b1;
        start_i = (mode == 3) && (c == 3);
        step();
        start_i = 1'b0;
        if (mode == 2 && r == 0 && c == 2) begin
          valid_i = 1'b0;
          step();
        end
      end
      if (mode == 1 && r < rows - 3) begin
        valid_i = 1'b0;
        step();
      end
    end
    valid_i = 1'b0;
    if (mode == 3) begin
      start_i = 1'b1;
      step();
      step();
      start_i = 1'b0;
    end
    for (int i = 0; i < 20 && done_q.size() == 0; i++) step();
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic check_frame(input string nm, input int cols, input int rows, input int mode);
    logic [20:0] exp_q[$];
    for (int r = 0; r < rows - 2; r++)
      for (int c = 0; c < cols - 2; c++)
        if (!(mode == 2 && r == 0 && c != 0))
          exp_q.push_back({10'(r), 10'(c), (c == cols - 3)});
    chk({nm, "_nwin"}, win_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_win%0d", nm, i), (i < win_q.size()) ? {11'd0, win_q[i]} : 32'hdead,
          {11'd0, exp_q[i]});
    chk({nm, "_ndone"}, done_q.size(), 1);
    if (done_q.size() > 0 && wcyc_q.size() > 0)
      chk({nm, "_done_lat"}, done_q[0] - wcyc_q[wcyc_q.size() - 1], 1);
    else
      chk({nm, "_done_lat"}, 0, 1);
    chk({nm, "_busy_end"}, m_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    valid_i = 1'b1;
    step();
    step();
    chk("rst_flags", {ready5, cen5, wv5, rend5, done5, busy5, err5}, 0);
    chk("rst_pos", {12'd0, row5, col5}, 0);
    chk("rst_flags84", {ready84, cen84, wv84, rend84, done84, busy84, err84}, 0);
    valid_i = 1'b0;
    step();
    rst = 1'b0;
    mon_en = 1'b1;
    clear_q();

    run_frame(5, 5, 0);
    check_frame("nom", 5, 5, 0);
    if (acc_q.size() > 0 && wcyc_q.size() > 0) chk("first_lat", wcyc_q[0] - acc_q[0], 4);
    else chk("first_lat", 0, 4);
    chk("nom_acc", acc_q.size(), 15);
    chk("nom_err", m_err, 1'b0);

    clear_q();
    run_frame(5, 5, 1);
    check_frame("rowgap", 5, 5, 1);
    chk("rowgap_err", m_err, 1'b0);

    clear_q();
    run_frame(5, 5, 2);
    check_frame("midgap", 5, 5, 2);
    chk("midgap_err", m_err, 1'b1);

    clear_q();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("start_clr_err", m_err, 1'b0);
    for (int i = 0; i < 7; i++) begin
      valid_i = 1'b1;
      step();
    end
    valid_i = 1'b0;
    chk("abort_busy_pre", m_busy, 1'b1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("abort_ndone", done_q.size(), 0);
    chk("abort_busy", m_busy, 1'b0);
    clear_q();
    run_frame(5, 5, 0);
    check_frame("post_abort", 5, 5, 0);

    sel84 = 1'b1;
    do_reset();
    run_frame(8, 4, 3);
    check_frame("c8r4", 8, 4, 3);
    chk("c8r4_acc", acc_q.size(), 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
